// File: rtl/band_envelope_follower.sv
// Per-band full-wave envelope follower with attack/release smoothing and one shared multiplier.
// Optional macro ENV_OVERRUN_COUNT_EN adds a saturating dropped-frame counter output.
module band_envelope_follower #(
  parameter int          FILTERS       = 9,
  parameter logic [31:0] ATTACK_COEFF  = 32'd524288,
  parameter logic [31:0] RELEASE_COEFF = 32'd65536
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       valid_in,
  input  logic [32*FILTERS-1:0]      bands_in,
  output logic signed [31:0]         env_out,
  output logic [$clog2(FILTERS)-1:0] env_band_out,
  output logic                       env_valid_out,
  output logic                       frame_done_out,
  output logic                       busy_out,
  output logic                       overrun_out
`ifdef ENV_OVERRUN_COUNT_EN
  ,
  output logic [15:0]                overrun_count_out
`endif
);

  localparam int KW = $clog2(FILTERS);
  localparam logic signed [31:0] ENV_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, ABS, UPD} state_t;

  // |x| with the single unrepresentable magnitude pinned to full scale
  function automatic logic signed [31:0] abs_sat(input logic signed [31:0] x);
    if (x == 32'sh8000_0000) return ENV_MAX;
    else if (x < 0)          return -x;
    else                     return x;
  endfunction

  function automatic logic signed [31:0] clamp_env(input logic signed [65:0] x);
    if (x < 0)                        return '0;
    else if (x > 66'sd2147483647)     return ENV_MAX;
    else                              return x[31:0];
  endfunction

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic [32*FILTERS-1:0] frame_q;
  logic signed [31:0]    env_q [FILTERS];
  logic signed [32:0]    diff_p0_q;
  logic signed [31:0]    coef_p0_q;
  logic signed [31:0]    env_out_q;
  logic [KW-1:0]         band_out_q;
  logic                  env_vld_q;
  logic                  frame_done_q;
  logic                  busy_q;
  logic                  overrun_q;
`ifdef ENV_OVERRUN_COUNT_EN
  logic [15:0]           ovr_cnt_q;
`endif

  logic signed [31:0] band_sel;
  logic signed [31:0] env_sel;
  logic signed [31:0] abs_val;
  logic signed [32:0] diff_d;
  logic signed [31:0] coef_d;
  logic signed [64:0] prod_p1;
  logic signed [65:0] sum_p1;
  logic signed [31:0] env_new;

  // ABS stage: rectify, error against current envelope, pick coefficient
  assign band_sel = $signed(frame_q[32*k_q +: 32]);
  assign env_sel  = env_q[k_q];
  assign abs_val  = abs_sat(band_sel);
  assign diff_d   = 33'(abs_val) - 33'(env_sel);
  assign coef_d   = (abs_val > env_sel) ? $signed(ATTACK_COEFF) : $signed(RELEASE_COEFF);

  // UPD stage: shared multiply, floor-shift back to Q0, clamp into envelope range
  assign prod_p1  = diff_p0_q * coef_p0_q;
  assign sum_p1   = 66'(env_sel) + 66'(prod_p1 >>> 20);
  assign env_new  = clamp_env(sum_p1);

  always_ff @(posedge clk_in) begin
    if (state_q == IDLE && valid_in) frame_q <= bands_in;
    if (state_q == ABS) begin
      diff_p0_q <= diff_d;
      coef_p0_q <= coef_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      k_q          <= '0;
      env_out_q    <= '0;
      band_out_q   <= '0;
      env_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef ENV_OVERRUN_COUNT_EN
      ovr_cnt_q    <= '0;
`endif
      for (int i = 0; i < FILTERS; i++) env_q[i] <= '0;
    end else begin
      env_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (valid_in && busy_q) begin
        overrun_q <= 1'b1;
`ifdef ENV_OVERRUN_COUNT_EN
        if (ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
`endif
      end
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            state_q <= ABS;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ABS: state_q <= UPD;
        UPD: begin
          env_q[k_q] <= env_new;
          env_out_q  <= env_new;
          band_out_q <= k_q;
          env_vld_q  <= 1'b1;
          if (k_q == KW'(FILTERS - 1)) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            k_q     <= k_q + KW'(1);
            state_q <= ABS;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign env_out        = env_out_q;
  assign env_band_out   = band_out_q;
  assign env_valid_out  = env_vld_q;
  assign frame_done_out = frame_done_q;
  assign busy_out       = busy_q;
  assign overrun_out    = overrun_q;
`ifdef ENV_OVERRUN_COUNT_EN
  assign overrun_count_out = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_band_envelope_follower.sv
// Self-checking bench for band_envelope_follower against an arithmetic envelope model.
module tb_band_envelope_follower;
  localparam int NF = 9;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid = 1'b0;
  logic [32*NF-1:0]     bands = '0;
  logic signed [31:0]   env_out;
  logic [3:0]           env_band;
  logic                 env_valid, frame_done, busy, overrun;
`ifdef ENV_OVERRUN_COUNT_EN
  logic [15:0]          ovr_cnt;
`endif

  band_envelope_follower dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .bands_in(bands),
    .env_out(env_out), .env_band_out(env_band), .env_valid_out(env_valid),
    .frame_done_out(frame_done), .busy_out(busy), .overrun_out(overrun)
`ifdef ENV_OVERRUN_COUNT_EN
    , .overrun_count_out(ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     n_pass = 0;
  int     n_total = 0;
  longint env_m [NF];
  longint exp_q [$];
  int     pn [$];
  int     pb [$];
  longint pe [$];
  bit     pf [$];
  bit     busy_tr [0:63];

  // envelope += floor((|x| - envelope) * coeff / 2^20), kept in [0, 2^31-1]
  function automatic void model_frame(input logic [32*NF-1:0] b);
    for (int k = 0; k < NF; k++) begin
      longint x, a, d, c, num, q, e;
      x = longint'($signed(b[32*k +: 32]));
      a = (x < 0) ? -x : x;
      if (a > 64'sd2147483647) a = 64'sd2147483647;
      d = a - env_m[k];
      c = (a > env_m[k]) ? 64'sd524288 : 64'sd65536;
      num = d * c;
      q = num / 64'sd1048576;
      if ((num % 64'sd1048576) != 0 && num < 0) q = q - 1;
      e = env_m[k] + q;
      if (e < 0) e = 0;
      if (e > 64'sd2147483647) e = 64'sd2147483647;
      env_m[k] = e;
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [32*NF-1:0] fill(input logic [31:0] v);
    logic [32*NF-1:0] r;
    for (int k = 0; k < NF; k++) r[32*k +: 32] = v;
    return r;
  endfunction

  function automatic logic [32*NF-1:0] rand_frame();
    logic [32*NF-1:0] r;
    for (int k = 0; k < NF; k++) begin
      case ($urandom_range(0, 5))
        0:       r[32*k +: 32] = 32'h8000_0000;
        1:       r[32*k +: 32] = 32'h7FFF_FFFF;
        2:       r[32*k +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
        default: r[32*k +: 32] = $urandom;
      endcase
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NF; k++) env_m[k] = 0;
  endtask

  // Launch one frame and record every output pulse by cycle offset n (n=0: cycle after accept edge)
  task automatic collect(input logic [32*NF-1:0] b, input int extra_at, input int rst_at,
                         input int ncyc);
    pn.delete(); pb.delete(); pe.delete(); pf.delete();
    @(negedge clk);
    bands = b;
    valid = 1'b1;
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge clk);
      if (n < 64) busy_tr[n] = busy;
      if (env_valid) begin
        pn.push_back(n);
        pb.push_back(int'(env_band));
        pe.push_back(longint'(env_out));
        pf.push_back(frame_done);
      end
      valid = (n == extra_at);
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total += 6;
    if (env_out !== 32'sd0) $display("FAIL reset_env_out got %0d want 0", env_out); else n_pass++;
    if (env_band !== 4'd0) $display("FAIL reset_band got %0d want 0", env_band); else n_pass++;
    if (env_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", env_valid); else n_pass++;
    if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < NF; k++) env_m[k] = 0;
  endtask

  task automatic test_frames();
    logic [32*NF-1:0] fr [$];
    fr.push_back(fill(32'd1000));
    fr.push_back(fill(32'd1000));
    fr.push_back(fill(-32'd1000));
    fr.push_back('x);
    fr.push_back(fill(32'd1000));
    fr.push_back(fill(32'd1000));
    fr.push_back(fill(32'd0));
    for (int r = 0; r < 6; r++) fr.push_back(rand_frame());
    foreach (fr[f]) begin
      if ($isunknown(fr[f])) begin
        do_reset();
        continue;
      end
      exp_q.delete();
      model_frame(fr[f]);
      collect(fr[f], -1, -1, 22);
      n_total++;
      if (pn.size() !== NF) $display("FAIL frame%0d_count got %0d want %0d", f, pn.size(), NF);
      else n_pass++;
      for (int i = 0; i < pn.size() && i < NF; i++) begin
        n_total += 4;
        if (pn[i] !== 2*i+2) $display("FAIL frame%0d_latency band %0d got %0d want %0d", f, i, pn[i], 2*i+2); else n_pass++;
        if (pb[i] !== i) $display("FAIL frame%0d_band got %0d want %0d", f, pb[i], i); else n_pass++;
        if (pe[i] !== exp_q[i]) $display("FAIL frame%0d_env band %0d got %0d want %0d", f, i, pe[i], exp_q[i]); else n_pass++;
        if (pf[i] !== (i == NF-1)) $display("FAIL frame%0d_done band %0d got %b want %b", f, i, pf[i], i == NF-1); else n_pass++;
      end
      for (int n = 0; n <= 22; n++) begin
        n_total++;
        if (busy_tr[n] !== (n <= 17)) $display("FAIL frame%0d_busy n=%0d got %b want %b", f, n, busy_tr[n], n <= 17);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [32*NF-1:0] b;
    do_reset();
    b = '0;
    b[32*3 +: 32] = 32'h8000_0000;
    exp_q.delete();
    model_frame(b);
    collect(b, -1, -1, 20);
    n_total++;
    if (pn.size() !== NF) $display("FAIL sat_count got %0d want %0d", pn.size(), NF); else n_pass++;
    for (int i = 0; i < pn.size() && i < NF; i++) begin
      n_total += 2;
      if (pe[i] !== exp_q[i]) $display("FAIL sat_env band %0d got %0d want %0d", i, pe[i], exp_q[i]); else n_pass++;
      if (pe[i] !== ((i == 3) ? 64'sd1073741823 : 64'sd0)) $display("FAIL sat_literal band %0d got %0d", i, pe[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [32*NF-1:0] b;
    b = rand_frame();
    exp_q.delete();
    model_frame(b);
    model_frame(b);
    collect(b, 18, -1, 40);
    n_total += 3;
    if (pn.size() !== 2*NF) $display("FAIL b2b_count got %0d want %0d", pn.size(), 2*NF); else n_pass++;
    if (busy_tr[18] !== 1'b0) $display("FAIL b2b_busy_gap got %b want 0", busy_tr[18]); else n_pass++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else n_pass++;
    for (int i = 0; i < pn.size() && i < 2*NF; i++) begin
      int k, wn;
      k = i % NF;
      wn = (i < NF) ? 2*k+2 : 21+2*k;
      n_total += 3;
      if (pn[i] !== wn) $display("FAIL b2b_latency idx %0d got %0d want %0d", i, pn[i], wn); else n_pass++;
      if (pb[i] !== k) $display("FAIL b2b_band idx %0d got %0d want %0d", i, pb[i], k); else n_pass++;
      if (pe[i] !== exp_q[i]) $display("FAIL b2b_env idx %0d got %0d want %0d", i, pe[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic [32*NF-1:0] b;
    do_reset();
    n_total++;
    if (overrun !== 1'b0) $display("FAIL ovr_pre got %b want 0", overrun); else n_pass++;
    b = rand_frame();
    exp_q.delete();
    model_frame(b);
    collect(b, 5, -1, 45);
    n_total += 2;
    if (pn.size() !== NF) $display("FAIL ovr_count got %0d want %0d", pn.size(), NF); else n_pass++;
    if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else n_pass++;
    for (int i = 0; i < pn.size() && i < NF; i++) begin
      n_total += 3;
      if (pn[i] !== 2*i+2) $display("FAIL ovr_latency band %0d got %0d want %0d", i, pn[i], 2*i+2); else n_pass++;
      if (pb[i] !== i) $display("FAIL ovr_band got %0d want %0d", pb[i], i); else n_pass++;
      if (pe[i] !== exp_q[i]) $display("FAIL ovr_env band %0d got %0d want %0d", i, pe[i], exp_q[i]); else n_pass++;
    end
`ifdef ENV_OVERRUN_COUNT_EN
    n_total++;
    if (ovr_cnt !== 16'd1) $display("FAIL ovr_cnt got %0d want 1", ovr_cnt); else n_pass++;
`endif
    repeat (5) @(negedge clk);
    n_total++;
    if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    collect(fill(32'd1000), -1, 6, 30);
    n_total += 7;
    if (pn.size() !== 3) $display("FAIL mid_pre_count got %0d want 3", pn.size()); else n_pass++;
    if (env_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", env_valid); else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
    if (env_out !== 32'sd0) $display("FAIL mid_env_out got %0d want 0", env_out); else n_pass++;
    if (env_band !== 4'd0) $display("FAIL mid_band got %0d want 0", env_band); else n_pass++;
    if (frame_done !== 1'b0) $display("FAIL mid_done got %b want 0", frame_done); else n_pass++;
    if (overrun !== 1'b0) $display("FAIL mid_overrun got %b want 0", overrun); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NF; k++) env_m[k] = 0;
    exp_q.delete();
    model_frame(fill(32'd1000));
    collect(fill(32'd1000), -1, -1, 20);
    n_total++;
    if (pn.size() !== NF) $display("FAIL mid_post_count got %0d want %0d", pn.size(), NF); else n_pass++;
    for (int i = 0; i < pn.size() && i < NF; i++) begin
      n_total += 2;
      if (pe[i] !== 64'sd500) $display("FAIL mid_post_env band %0d got %0d want 500", i, pe[i]); else n_pass++;
      if (pb[i] !== i) $display("FAIL mid_post_band got %0d want %0d", pb[i], i); else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frames();
    test_saturation();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/band_envelope_follower.md
Name: band_envelope_follower

Overview:
- Consumer of the per-band filterbank outputs: takes one frame of FILTERS signed band samples and updates a per-band amplitude envelope.
- Envelope uses full-wave rectification and one-pole attack/release smoothing.
- One time-multiplexed multiplier serves all bands; updated envelopes stream out one band at a time.
- Envelopes drive downstream vocoder gain stages.

Parameters:
- FILTERS, 9, number of bands per frame.
- ATTACK_COEFF, 32'd524288, Q20 smoothing coefficient used when |x| > env (0.5).
- RELEASE_COEFF, 32'd65536, Q20 smoothing coefficient used when |x| <= env (0.0625).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- valid_in  input  1  single-cycle strobe; bands_in is valid this cycle.
- bands_in  input  32*FILTERS  signed band samples; band k occupies bits [32k+31:32k].
- env_out  output  32  signed envelope of band env_band_out, range 0..2^31-1.
- env_band_out  output  $clog2(FILTERS)  band index of env_out.
- env_valid_out  output  1  one-cycle pulse per band output.
- frame_done_out  output  1  pulse coincident with the band FILTERS-1 output.
- busy_out  output  1  high while a frame is in progress.
- overrun_out  output  1  sticky flag: a frame was dropped.

Behaviour:
- Reset (rst_n_in low, asynchronous): all outputs 0, all envelope registers 0, FSM to IDLE. Applies immediately mid-frame; the partial frame is discarded.
- FSM states are IDLE, ABS, UPD.
- IDLE: on valid_in, capture all of bands_in into a frame register, set k=0, go to ABS. busy_out is high from the next cycle.
- ABS (one cycle):
  - a = |band k|, with -2^31 saturating to 2^31-1.
  - d = a - env[k], computed at 33-bit signed width.
  - c = ATTACK_COEFF if a > env[k], else RELEASE_COEFF.
- UPD (one cycle):
  - p = d*c, 33x32 signed product held at 65 bits.
  - env[k] <= clamp(env[k] + (p >>> 20), 0, 2^31-1). The shift is arithmetic, so results floor toward -inf.
  - Register env_out=new env[k], env_band_out=k, and pulse env_valid_out on the next cycle.
  - If k==FILTERS-1, also pulse frame_done_out and return to IDLE; otherwise k++ and go to ABS.
- Latency: with valid_in sampled at edge E0, the band k output is visible in the cycle after edge E0+2k+2.
- Frame period is 2*FILTERS cycles.
- busy_out drops in the same cycle as the last output, so a valid_in that cycle is accepted. Minimum valid_in spacing is 2*FILTERS+1 cycles.
- valid_in while busy_out is high: the frame is dropped and overrun_out is set. overrun_out clears only on reset. The frame in progress is unaffected.
- env_out, env_band_out hold their last value between pulses.
- Envelope state persists across frames.

Optional Feature:
- Macro ENV_OVERRUN_COUNT_EN.
- Defined: adds output port overrun_count_out (16 bits). It is a saturating count of dropped frames, stops at 16'hFFFF, and is 0 on reset.
- Undefined: port and counter absent; overrun_out behaviour is unchanged.

Test Plan:
1. Reset, then one frame with all bands=1000 -> 9 env_valid_out pulses, env_band_out 0..8, each env_out=500. frame_done_out with band 8. First pulse in the cycle after E0+2, last after E0+18.
2. Second identical frame -> each env_out=750. Then a frame of all bands=-1000 -> each env_out=875 (rectification).
3. Starting from env=750, a frame of all zeros -> release path gives 750 + floor(-750*65536/2^20) = 703 per band.
4. From reset, band 3 = -2^31 and the rest 0 -> band 3 env_out=1073741823, other bands 0.
5. valid_in pulsed 5 cycles after an accepted frame -> no extra outputs, the first frame completes correctly, overrun_out=1 until reset. With ENV_OVERRUN_COUNT_EN defined, overrun_count_out=1.
6. rst_n_in low mid-frame (after band 2 output) -> outputs and busy_out go 0 immediately. The next frame of 1000s yields 500 for every band, showing envelopes were cleared.
